// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared VGA timing, framebuffer geometry and host command types
package vga_pkg;

    localparam int H_START = 48;
    localparam int V_START = 33;
    localparam int FB_W    = 160;
    localparam int FB_H    = 120;
    localparam int ADDR_W  = 15;
    localparam int COLOR_W = 8;
    localparam int CMD_W   = 1 + ADDR_W + COLOR_W;

    typedef struct packed {
        logic               we;
        logic [ADDR_W-1:0]  addr;
        logic [COLOR_W-1:0] wdata;
    } host_cmd_t;

    // y*160 + x as (y<<7) + (y<<5) + x, so no multiplier is needed
    function automatic logic [ADDR_W-1:0] fb_addr_160(input logic [7:0] x, input logic [6:0] y);
        logic [ADDR_W-1:0] ye;
        ye = {8'b0, y};
        return (ye << 7) + (ye << 5) + {7'b0, x};
    endfunction

endpackage

// File: rtl/cmd_fifo.sv
// rtl/cmd_fifo.sv - small power-of-two host command FIFO
module cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 24
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [W-1:0]           din,
    input  logic                   pop,
    output logic [W-1:0]           dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] DEPTH_CNT = (PW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          push_ok;
    logic          pop_ok;

    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign full    = (count == DEPTH_CNT);
    assign empty   = (count == '0);
    assign dout    = mem[rd_ptr];

    // Entry storage needs no reset; only the pointers define validity
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fb_arbiter.sv
// rtl/fb_arbiter.sv - single-port framebuffer arbiter between VGA scan-out and host
module fb_arbiter #(
    parameter int H_START    = vga_pkg::H_START,
    parameter int V_START    = vga_pkg::V_START,
    parameter int FB_W       = vga_pkg::FB_W,
    parameter int FB_H       = vga_pkg::FB_H,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [9:0]                  col,
    input  logic [9:0]                  row,
    output logic [vga_pkg::COLOR_W-1:0] color,
    input  logic                        host_valid,
    output logic                        host_ready,
    input  logic                        host_we,
    input  logic [vga_pkg::ADDR_W-1:0]  host_addr,
    input  logic [vga_pkg::COLOR_W-1:0] host_wdata,
    output logic [vga_pkg::COLOR_W-1:0] host_rdata,
    output logic                        host_rvalid,
    output logic                        mem_en,
    output logic                        mem_we,
    output logic [vga_pkg::ADDR_W-1:0]  mem_addr,
    output logic [vga_pkg::COLOR_W-1:0] mem_wdata,
    input  logic [vga_pkg::COLOR_W-1:0] mem_rdata
);

    import vga_pkg::*;

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [9:0]        col_q;
    logic              init_q;
    logic              disp_q;
    logic              rd_pend;
    logic [9:0]        hx;
    logic [9:0]        vy;
    logic [7:0]        x;
    logic [6:0]        y;
    logic              visible;
    logic              slot;
    logic [ADDR_W-1:0] disp_addr;
    host_cmd_t         head;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_count;
    logic              push;
    logic              pop;

    assign hx      = col - 10'(H_START);
    assign vy      = row - 10'(V_START);
    assign x       = 8'(hx >> 2);
    assign y       = 7'(vy >> 2);
    assign visible = (col >= 10'(H_START)) && (hx < 10'(FB_W * 4)) &&
                     (row >= 10'(V_START)) && (vy < 10'(FB_H * 4));

    // init_q keeps memory quiet for the first cycle after reset release
    assign slot = visible && (col != col_q) && !init_q;

    generate
        if (FB_W == 160) begin : g_shift_add
            assign disp_addr = fb_addr_160(x, y);
        end else begin : g_mul
            assign disp_addr = ADDR_W'(y * FB_W + x);
        end
    endgenerate

    assign host_ready = (fifo_count != CNT_W'(FIFO_DEPTH));
    assign push       = host_valid && !fifo_full;
    assign pop        = !slot && !fifo_empty && !init_q;

    cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (CMD_W)
    ) u_cmd_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   ({host_we, host_addr, host_wdata}),
        .pop   (pop),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Display read wins the port; otherwise the FIFO head goes out
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (slot) begin
            mem_en   = 1'b1;
            mem_addr = disp_addr;
        end else if (pop) begin
            mem_en    = 1'b1;
            mem_we    = head.we;
            mem_addr  = head.addr;
            mem_wdata = head.wdata;
        end
    end

    // Scan history, read-return tracking and the held pixel colour
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q   <= '0;
            init_q  <= 1'b1;
            disp_q  <= 1'b0;
            rd_pend <= 1'b0;
            color   <= '0;
        end else begin
            col_q   <= col;
            init_q  <= 1'b0;
            disp_q  <= slot;
            rd_pend <= pop && !head.we;
            if (disp_q) begin
                color <= mem_rdata;
            end
        end
    end

    assign host_rvalid = rd_pend;
    assign host_rdata  = mem_rdata;

endmodule
